// File: rtl/risc_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// risc_ctrl_seq_if
// Bundles the sequencer's decode inputs and its control strobes to the
// PC/IR/ALU/memory datapath of the 8-bit RISC processor.
//   master : the sequencer (consumes opcode/zero, drives strobes + phase)
//   slave  : the datapath side (drives opcode/zero, consumes strobes)
// Signals:
//   opcode  IR[7:5]            zero    accumulator == 0
//   fch     1 = PC addr, 0 = IR operand addr
//   rd/wr   memory read enable / write strobe
//   ld_ir/ld_ac/ld_pc/inc_pc   register load / PC control strobes
//   data_e  accumulator onto data bus
//   halt    processor halted   phase   current sequencer phase
// ---------------------------------------------------------------------------
interface risc_ctrl_seq_if #(
  parameter int OP_W = 3,
  parameter int PH_W = 3
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            fch;
  logic            rd;
  logic            wr;
  logic            ld_ir;
  logic            ld_ac;
  logic            ld_pc;
  logic            inc_pc;
  logic            data_e;
  logic            halt;
  logic [PH_W-1:0] phase;

  modport master (
    input  opcode, zero,
    output fch, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  fch, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
  );
endinterface

// File: rtl/risc_ctrl_seq.sv
// ---------------------------------------------------------------------------
// risc_ctrl_seq
// Instruction sequencer for the 8-bit RISC processor. Each instruction takes
// eight phases (fetch in 0-3, execute in 4-7). Outputs are a combinational
// decode of {phase, opcode, zero, halted}; HLT freezes the sequencer in
// phase 4 until reset.
// Ports:
//   clk  in  single clock, rising edge
//   rst  in  synchronous, active-high reset; forces all outputs to 0
//   bus  risc_ctrl_seq_if.master: opcode/zero in, strobes/halt/phase out
// ---------------------------------------------------------------------------
module risc_ctrl_seq #(
  parameter int OP_W = 3,
  parameter int PH_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  risc_ctrl_seq_if.master bus
);

  typedef enum logic [PH_W-1:0] {
    S_INST_ADDR  = PH_W'(0),
    S_INST_FETCH = PH_W'(1),
    S_INST_LOAD  = PH_W'(2),
    S_IDLE       = PH_W'(3),
    S_OP_ADDR    = PH_W'(4),
    S_OP_FETCH   = PH_W'(5),
    S_ALU_OP     = PH_W'(6),
    S_STORE      = PH_W'(7)
  } phase_e;

  localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

  phase_e r_phase;
  logic   r_halted;

  phase_e w_phase_nxt;
  logic   w_halted_nxt;
  logic   w_aluop, w_skz, w_sto, w_jmp, w_hlt;
  logic   w_fch, w_rd, w_wr, w_ld_ir, w_ld_ac, w_ld_pc, w_inc_pc, w_data_e, w_halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= S_INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
              (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    w_skz   = (bus.opcode == OP_SKZ);
    w_sto   = (bus.opcode == OP_STO);
    w_jmp   = (bus.opcode == OP_JMP);
    w_hlt   = (bus.opcode == OP_HLT);
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_halted_nxt = r_halted;
    w_fch        = 1'b0;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_ld_ir      = 1'b0;
    w_ld_ac      = 1'b0;
    w_ld_pc      = 1'b0;
    w_inc_pc     = 1'b0;
    w_data_e     = 1'b0;
    w_halt       = 1'b0;

    if (r_halted) begin
      // Parked in phase 4: only halt stays up, and only reset leaves.
      w_halt = 1'b1;
    end else begin
      case (r_phase)
        S_INST_ADDR: begin
          w_fch       = 1'b1;
          w_phase_nxt = S_INST_FETCH;
        end
        S_INST_FETCH: begin
          w_fch       = 1'b1;
          w_rd        = 1'b1;
          w_phase_nxt = S_INST_LOAD;
        end
        S_INST_LOAD: begin
          w_fch       = 1'b1;
          w_rd        = 1'b1;
          w_ld_ir     = 1'b1;
          w_phase_nxt = S_IDLE;
        end
        S_IDLE: begin
          w_fch       = 1'b1;
          w_rd        = 1'b1;
          w_ld_ir     = 1'b1;
          w_phase_nxt = S_OP_ADDR;
        end
        S_OP_ADDR: begin
          // inc_pc fires once here even for HLT; the halted flag then
          // suppresses it on every following cycle.
          w_inc_pc = 1'b1;
          if (w_hlt) begin
            w_halt       = 1'b1;
            w_halted_nxt = 1'b1;
            w_phase_nxt  = S_OP_ADDR;
          end else begin
            w_phase_nxt = S_OP_FETCH;
          end
        end
        S_OP_FETCH: begin
          w_rd        = w_aluop;
          w_phase_nxt = S_ALU_OP;
        end
        S_ALU_OP: begin
          w_rd        = w_aluop;
          w_inc_pc    = w_skz & bus.zero;
          w_ld_pc     = w_jmp;
          // data_e leads wr by a cycle so the bus is settled before the write.
          w_data_e    = w_sto;
          w_phase_nxt = S_STORE;
        end
        S_STORE: begin
          w_rd        = w_aluop;
          w_ld_ac     = w_aluop;
          w_ld_pc     = w_jmp;
          w_inc_pc    = w_jmp;
          w_wr        = w_sto;
          w_data_e    = w_sto;
          w_phase_nxt = S_INST_ADDR;
        end
        default: w_phase_nxt = S_INST_ADDR;
      endcase
    end
  end

  // Reset masks every output so no strobe completes while it is held.
  assign bus.fch    = w_fch    & ~rst;
  assign bus.rd     = w_rd     & ~rst;
  assign bus.wr     = w_wr     & ~rst;
  assign bus.ld_ir  = w_ld_ir  & ~rst;
  assign bus.ld_ac  = w_ld_ac  & ~rst;
  assign bus.ld_pc  = w_ld_pc  & ~rst;
  assign bus.inc_pc = w_inc_pc & ~rst;
  assign bus.data_e = w_data_e & ~rst;
  assign bus.halt   = w_halt   & ~rst;
  assign bus.phase  = rst ? PH_W'(0) : r_phase;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
module tb_risc_ctrl_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  risc_ctrl_seq_if #(.OP_W(3), .PH_W(3)) u_if ();

  risc_ctrl_seq #(.OP_W(3), .PH_W(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Instruction progress is counted in cycles since reset; phase is that
  // count modulo 8, and a halted processor simply stops counting.
  int m_cnt  = 0;
  bit m_halt = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_halt <= 1'b0;
    end else if (!m_halt) begin
      if ((m_cnt % 8) == 4 && u_if.opcode == 3'd0) m_halt <= 1'b1;
      else                                         m_cnt  <= m_cnt + 1;
    end
  end

  // Packed order: fch rd wr ld_ir ld_ac ld_pc inc_pc data_e halt phase[2:0]
  function automatic logic [11:0] model_out(int ph, bit h, bit r, logic [2:0] op, logic z);
    bit alu, sto, jmp, skz;
    bit fch, rd, wr, ldir, ldac, ldpc, inc, de, hl;
    if (r) return 12'h000;
    if (h) return {8'b0, 1'b1, 3'd4};
    alu  = (op >= 3'd2) && (op <= 3'd5);
    sto  = (op == 3'd6);
    jmp  = (op == 3'd7);
    skz  = (op == 3'd1);
    fch  = (ph < 4);
    rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    ldir = (ph == 2 || ph == 3);
    wr   = (ph == 7) && sto;
    ldac = (ph == 7) && alu;
    ldpc = (ph >= 6) && jmp;
    inc  = (ph == 4) || (ph == 6 && skz && z == 1'b1) || (ph == 7 && jmp);
    de   = (ph >= 6) && sto;
    hl   = (ph == 4) && (op == 3'd0);
    return {fch, rd, wr, ldir, ldac, ldpc, inc, de, hl, 3'(ph)};
  endfunction

  function automatic logic [11:0] dut_out();
    return {u_if.fch, u_if.rd, u_if.wr, u_if.ld_ir, u_if.ld_ac, u_if.ld_pc,
            u_if.inc_pc, u_if.data_e, u_if.halt, u_if.phase};
  endfunction

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_cmp", 32'(dut_out()),
        32'(model_out(m_cnt % 8, m_halt, rst, u_if.opcode, u_if.zero)));
  end

  // ---------------- directed helpers ----------------
  // Called one delta after a rising edge with the DUT in phase 0.
  task automatic run8(input logic [2:0] op, input logic z,
                      output logic [7:0] v_fch, output logic [7:0] v_rd,
                      output logic [7:0] v_wr,  output logic [7:0] v_ldac,
                      output logic [7:0] v_ldpc, output logic [7:0] v_inc,
                      output logic [7:0] v_de);
    u_if.opcode = op;
    u_if.zero   = z;
    chk("start_phase", 32'(u_if.phase), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v_fch[i]  = u_if.fch;
      v_rd[i]   = u_if.rd;
      v_wr[i]   = u_if.wr;
      v_ldac[i] = u_if.ld_ac;
      v_ldpc[i] = u_if.ld_pc;
      v_inc[i]  = u_if.inc_pc;
      v_de[i]   = u_if.data_e;
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] f, r, w, la, lp, ic, de;
  int inc_cnt, hcnt, hlim;

  initial begin
    u_if.opcode = 3'd5;
    u_if.zero   = 1'b0;
    rst         = 1'b1;

    // Reset: all outputs forced low while rst is high.
    @(negedge clk);
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LDA
    run8(3'd5, 1'b0, f, r, w, la, lp, ic, de);
    chk("lda_fch",   32'(f),  32'h0F);
    chk("lda_rd",    32'(r),  32'hEE);
    chk("lda_ld_ac", 32'(la), 32'h80);
    chk("lda_wr",    32'(w),  32'h00);

    // STO
    run8(3'd6, 1'b0, f, r, w, la, lp, ic, de);
    chk("sto_data_e", 32'(de), 32'hC0);
    chk("sto_wr",     32'(w),  32'h80);
    chk("sto_rd",     32'(r),  32'h0E);

    // SKZ with zero=1 then zero=0
    run8(3'd1, 1'b1, f, r, w, la, lp, ic, de);
    chk("skz_z1_inc", 32'(ic), 32'h50);
    run8(3'd1, 1'b0, f, r, w, la, lp, ic, de);
    chk("skz_z0_inc", 32'(ic), 32'h10);
    chk("skz_z0_rd",  32'(r),  32'h0E);

    // JMP
    run8(3'd7, 1'b1, f, r, w, la, lp, ic, de);
    chk("jmp_ld_pc", 32'(lp), 32'hC0);
    chk("jmp_inc",   32'(ic), 32'h90);
    chk("jmp_rd",    32'(r),  32'h0E);
    chk("jmp_wr",    32'(w),  32'h00);

    // XOR: ALU op behaves like LDA on the strobes
    run8(3'd4, 1'b0, f, r, w, la, lp, ic, de);
    chk("xor_ld_ac", 32'(la), 32'h80);
    chk("xor_rd",    32'(r),  32'hEE);

    // Reset in the middle of an instruction (phase 6)
    u_if.opcode = 3'd2;
    repeat (6) @(posedge clk);
    #1;
    chk("midop_phase6", 32'(u_if.phase), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_rst_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midop_after_phase", 32'(u_if.phase), 32'd0);
    chk("midop_after_fch",   32'(u_if.fch),   32'd1);
    repeat (8) @(posedge clk);
    #1;

    // HLT: sticks in phase 4, single inc_pc pulse, cleared by reset
    chk("hlt_start_phase", 32'(u_if.phase), 32'd0);
    u_if.opcode = 3'd0;
    repeat (4) @(negedge clk);
    inc_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (u_if.phase !== 3'd4 || u_if.halt !== 1'b1)
        chk("hlt_hold", 32'({u_if.halt, u_if.phase}), 32'({1'b1, 3'd4}));
      if (u_if.inc_pc === 1'b1) inc_cnt++;
    end
    chk("hlt_halt",     32'(u_if.halt),  32'd1);
    chk("hlt_phase",    32'(u_if.phase), 32'd4);
    chk("hlt_inc_once", 32'(inc_cnt),    32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("hlt_rst_halt", 32'(u_if.halt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("hlt_after_halt",  32'(u_if.halt),  32'd0);
    chk("hlt_after_phase", 32'(u_if.phase), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic; the negedge compare process checks every cycle.
    hcnt = 0;
    hlim = 22;
    for (int c = 0; c < 4000; c++) begin
      if (m_halt) hcnt++;
      else        hcnt = 0;
      rst = (m_halt && hcnt >= hlim) || ($urandom_range(0, 199) == 0);
      if (rst) hlim = $urandom_range(1, 30);
      if (!rst && (m_cnt % 8) == 0) u_if.opcode = 3'($urandom_range(0, 7));
      u_if.zero = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
